// File: rtl/count_uart_reporter_if.sv
// Bundle of the counter-side inputs and the UART/status outputs of count_uart_reporter.
interface count_uart_reporter_if;
    logic [7:0] count_in;
    logic       enable;
    logic       force_send;
    logic       tx;
    logic       busy;
    logic       frame_done;

    modport master (
        output count_in, enable, force_send,
        input  tx, busy, frame_done
    );

    modport slave (
        input  count_in, enable, force_send,
        output tx, busy, frame_done
    );
endinterface

// File: rtl/count_uart_reporter.sv
// Reports each new 8-bit count as "HH\r\n" over UART 8N1; frames start only from IDLE,
// and values that arrive while a frame is in flight collapse to the latest one.
module count_uart_reporter #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic                  clk,
    input  logic                  rst_n,
    count_uart_reporter_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       shadow_q, shadow_d;
    logic [7:0]       last_q, last_d;
    logic [1:0]       char_q, char_d;
    logic [2:0]       bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [7:0]       char_byte_c;
    logic             bit_end_c;
    logic             trig_c;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    // Character currently on the wire, taken from the frame's captured count.
    always_comb begin
        case (char_q)
            2'd0:    char_byte_c = hex_char(shadow_q[7:4]);
            2'd1:    char_byte_c = hex_char(shadow_q[3:0]);
            2'd2:    char_byte_c = 8'h0D;
            default: char_byte_c = 8'h0A;
        endcase
    end

    assign bit_end_c = (cnt_q == BIT_LAST);
    assign trig_c    = bus.force_send | (bus.enable & (bus.count_in != last_q));

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        last_d   = last_q;
        char_d   = char_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        // Bit-period counter free-runs while a frame is active, reloading at every boundary.
        if (state_q != IDLE) begin
            cnt_d = bit_end_c ? '0 : (cnt_q + CNT_W'(1));
        end

        case (state_q)
            IDLE: begin
                if (trig_c) begin
                    shadow_d = bus.count_in;
                    last_d   = bus.count_in;
                    state_d  = START;
                    busy_d   = 1'b1;
                    tx_d     = 1'b0;
                    cnt_d    = '0;
                    char_d   = 2'd0;
                    bit_d    = 3'd0;
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = char_byte_c[0];
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = char_byte_c[bit_q + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    if (char_q != 2'd3) begin
                        char_d  = char_q + 2'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        char_d  = 2'd0;
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= 8'h00;
            last_q   <= 8'h00;
            char_q   <= 2'd0;
            bit_q    <= 3'd0;
            cnt_q    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            last_q   <= last_d;
            char_q   <= char_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

endmodule
